// File: rtl/btn_debounce_pulse_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encodings and
// default timing constants.
package btn_debounce_pulse_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM_ON  = 2'd1,
      S_ON      = 2'd2,
      S_ARM_OFF = 2'd3
   } state_t;

   // 10 ms at 50 MHz
   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int CNT_W_DEF           = 19;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit; the reset value
// is a parameter so each input can reset to its own inactive level.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic meta_p0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         meta_p0 <= RST_VAL;
         q       <= RST_VAL;
      end else begin
         meta_p0 <= d;
         q       <= meta_p0;
      end
   end

endmodule

// File: rtl/btn_debounce_pulse.sv
// Debounces one raw button pin into a registered level plus one-cycle press
// and release strobes; the level feeds the toggle-state Mealy block.
module btn_debounce_pulse
   import btn_debounce_pulse_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int CNT_W           = CNT_W_DEF,
   parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             level_nxt, rise_nxt, fall_nxt;
   logic             btn_raw;
   logic             s_btn;

   // Normalise polarity before synchronising so the synchronizer resets to "not pressed".
   assign btn_raw = btn_in ^ BTN_ACTIVE_LOW;

   sync_2ff #(
      .RST_VAL (1'b0)
   ) u_sync (
      .clk  (clk),
      .rstn (rstn),
      .d    (btn_raw),
      .q    (s_btn)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_IDLE;
         cnt       <= '0;
         btn_level <= 1'b0;
         btn_rise  <= 1'b0;
         btn_fall  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         btn_level <= level_nxt;
         btn_rise  <= rise_nxt;
         btn_fall  <= fall_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (s_btn) begin
               state_nxt = S_ARM_ON;
               cnt_nxt   = '0;
            end
         end
         S_ARM_ON: begin
            if (!s_btn) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_ON;
               cnt_nxt   = '0;
               rise_nxt  = 1'b1;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         S_ON: begin
            if (!s_btn) begin
               state_nxt = S_ARM_OFF;
               cnt_nxt   = '0;
            end
         end
         S_ARM_OFF: begin
            if (s_btn) begin
               state_nxt = S_ON;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               fall_nxt  = 1'b1;
            end else begin
               cnt_nxt   = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
         end
      endcase
      // Level is registered from the next state so it can never glitch.
      level_nxt = (state_nxt == S_ON) || (state_nxt == S_ARM_OFF);
   end

endmodule
